// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel gradient stage.
package sobel_pkg;

    localparam int              PIX_W   = 8;
    localparam int              GRAD_W  = 11;
    localparam logic [PIX_W-1:0] SAT_MAX = 8'd255;

    typedef logic signed [GRAD_W-1:0] grad_t;

    // Row slots inside a window column: top = r-2, mid = r-1, bottom = r.
    localparam int W_TOP = 0;
    localparam int W_MID = 1;
    localparam int W_BOT = 2;

endpackage

// File: rtl/sobel_line_buf.sv
// Two cascaded line RAMs: buffer 0 holds the previous line, buffer 1 the one before.
module sobel_line_buf #(
    parameter int DEPTH = 64,
    parameter int PIX_W = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [PIX_W-1:0] din_i,
    output logic [PIX_W-1:0] row1_o,
    output logic [PIX_W-1:0] row2_o
);

    logic [PIX_W-1:0] mem0 [DEPTH];
    logic [PIX_W-1:0] mem1 [DEPTH];
    logic [PIX_W-1:0] rd0_q;
    logic [PIX_W-1:0] rd1_q;

    // Read-before-write: the old line-0 entry ages into line 1 at the same index.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem0[addr_i] <= din_i;
            mem1[addr_i] <= mem0[addr_i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd0_q <= '0;
            rd1_q <= '0;
        end else if (we_i) begin
            rd0_q <= mem0[addr_i];
            rd1_q <= mem1[addr_i];
        end
    end

    assign row1_o = rd0_q;
    assign row2_o = rd1_q;

endmodule

// File: rtl/sobel_grad_stage.sv
// Streaming 3x3 Sobel stage: raster pixels in, saturated |Gx|/|Gy| operands out.
module sobel_grad_stage #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pix,
    input  logic             in_sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_gx_abs,
    output logic [PIX_W-1:0] out_gy_abs,
    output logic             out_eol,
    output logic             out_eof
);

    import sobel_pkg::*;

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    function automatic grad_t ext(input logic [PIX_W-1:0] p);
        return grad_t'({{(GRAD_W-PIX_W){1'b0}}, p});
    endfunction

    function automatic logic [PIX_W-1:0] abs_sat(input grad_t g);
        grad_t a;
        a = g[GRAD_W-1] ? -g : g;
        if (a > grad_t'(SAT_MAX))
            return SAT_MAX;
        return a[PIX_W-1:0];
    endfunction

    logic             en;
    logic             acc;
    logic [CW-1:0]    col_q, col_d, c_cur;
    logic [RW-1:0]    row_q, row_d, r_cur;
    logic             win_ok;
    logic [PIX_W-1:0] lb_mid, lb_top;

    logic [PIX_W-1:0] pix_q;
    logic [PIX_W-1:0] win_a_q [3];
    logic [PIX_W-1:0] win_b_q [3];
    logic [PIX_W-1:0] win_c   [3];
    logic             vld1_q, eol1_q, eof1_q;

    logic             out_valid_q;
    logic [PIX_W-1:0] gx_q, gy_q;
    logic             eol_q, eof_q;
    grad_t            gx, gy;

    assign en       = out_ready | ~out_valid_q;
    assign in_ready = en;
    assign acc      = in_valid & en;

    // in_sof forces the accepted pixel to the frame origin.
    always_comb begin
        c_cur  = in_sof ? '0 : col_q;
        r_cur  = in_sof ? '0 : row_q;
        col_d  = col_q;
        row_d  = row_q;
        win_ok = (c_cur >= CW'(2)) && (r_cur >= RW'(2));
        if (acc) begin
            if (c_cur == COL_LAST) begin
                col_d = '0;
                row_d = (r_cur == ROW_LAST) ? '0 : r_cur + RW'(1);
            end else begin
                col_d = c_cur + CW'(1);
                row_d = r_cur;
            end
        end
    end

    sobel_line_buf #(
        .DEPTH (IMG_W),
        .PIX_W (PIX_W),
        .AW    (CW)
    ) u_line_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (acc),
        .addr_i (c_cur),
        .din_i  (in_pix),
        .row1_o (lb_mid),
        .row2_o (lb_top)
    );

    // S1: counters, window shift; column c is the line-buffer read data plus pix_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            pix_q   <= '0;
            vld1_q  <= 1'b0;
            eol1_q  <= 1'b0;
            eof1_q  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                win_a_q[i] <= '0;
                win_b_q[i] <= '0;
            end
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            if (en)
                vld1_q <= acc & win_ok;
            if (acc) begin
                pix_q          <= in_pix;
                win_a_q        <= win_b_q;
                win_b_q[W_TOP] <= lb_top;
                win_b_q[W_MID] <= lb_mid;
                win_b_q[W_BOT] <= pix_q;
                eol1_q         <= (c_cur == COL_LAST);
                eof1_q         <= (c_cur == COL_LAST) && (r_cur == ROW_LAST);
            end
        end
    end

    always_comb begin
        win_c[W_TOP] = lb_top;
        win_c[W_MID] = lb_mid;
        win_c[W_BOT] = pix_q;
        gx = (ext(win_c[W_TOP]) + (ext(win_c[W_MID]) <<< 1) + ext(win_c[W_BOT]))
           - (ext(win_a_q[W_TOP]) + (ext(win_a_q[W_MID]) <<< 1) + ext(win_a_q[W_BOT]));
        gy = (ext(win_a_q[W_BOT]) + (ext(win_b_q[W_BOT]) <<< 1) + ext(win_c[W_BOT]))
           - (ext(win_a_q[W_TOP]) + (ext(win_b_q[W_TOP]) <<< 1) + ext(win_c[W_TOP]));
    end

    // S2: abs/saturate into the output register; held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            gx_q        <= '0;
            gy_q        <= '0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
        end else if (en) begin
            out_valid_q <= vld1_q;
            if (vld1_q) begin
                gx_q  <= abs_sat(gx);
                gy_q  <= abs_sat(gy);
                eol_q <= eol1_q;
                eof_q <= eof1_q;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_gx_abs = gx_q;
    assign out_gy_abs = gy_q;
    assign out_eol    = eol_q;
    assign out_eof    = eof_q;

endmodule

// File: tb/tb_sobel_grad_stage.sv
// Bench for sobel_grad_stage: frame-level reference model, table of frame cases, abort/reset sequences.
module tb_sobel_grad_stage;

    localparam int W = 64;
    localparam int H = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_pix = '0;
    logic       in_sof = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_gx_abs;
    logic [7:0] out_gy_abs;
    logic       out_eol;
    logic       out_eof;

    sobel_grad_stage #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pix     (in_pix),
        .in_sof     (in_sof),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_gx_abs (out_gx_abs),
        .out_gy_abs (out_gy_abs),
        .out_eol    (out_eol),
        .out_eof    (out_eof)
    );

    always #5 clk = ~clk;

    typedef struct {
        int gx;
        int gy;
        bit eol;
        bit eof;
        int r;
        int c;
    } out_t;

    typedef struct {
        int kind;      // 0 uniform, 1 ramp 4*col, 2 vertical step, 3 random
        int val;
        int stall;     // 0 none, 1 ready 1-0-0, 2 random ready and valid gaps
        bit sof;
        int probe_c;   // center column probed on center row 10, -1 = none
        int exp_gx;
        int exp_gy;
    } case_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    out_t exp_q[$];
    int   img [H][W];
    int   mr = 0, mc = 0;
    int   cyc = 0;
    int   out_cnt, eol_cnt, eof_cnt;
    int   probe_r, probe_c, probe_gx, probe_gy;
    bit   held_v = 1'b0;
    logic [7:0] held_gx, held_gy;
    logic held_eol, held_eof;
    bit   hung = 1'b0;

    function automatic int sat(input int v);
        int a;
        a = (v < 0) ? -v : v;
        return (a > 255) ? 255 : a;
    endfunction

    function automatic int gen(input int kind, input int val, input int c);
        case (kind)
            0:       return val;
            1:       return 4 * c;
            2:       return (c < 32) ? 0 : 200;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    // Reference: keep the frame image, emit a center result whenever a full 3x3 exists.
    task automatic model_accept(input int pix, input bit sof);
        int   r, c, gx, gy;
        out_t e;
        if (sof) begin
            mr = 0;
            mc = 0;
        end
        r = mr;
        c = mc;
        img[r][c] = pix;
        if (r >= 2 && c >= 2) begin
            gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
               - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
            gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
               - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
            e.gx  = sat(gx);
            e.gy  = sat(gy);
            e.eol = (c == W-1);
            e.eof = (c == W-1) && (r == H-1);
            e.r   = r - 1;
            e.c   = c - 1;
            exp_q.push_back(e);
        end
        mc++;
        if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) mr = 0;
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic cycle(input bit v, input int pix, input bit sof, input bit ordy, output bit acc);
        out_t e;
        @(negedge clk);
        in_valid  = v;
        in_pix    = pix[7:0];
        in_sof    = sof;
        out_ready = ordy;
        cyc++;
        #1;
        acc = v && in_ready;
        if (held_v) begin
            n_tests++;
            if (!out_valid || out_gx_abs !== held_gx || out_gy_abs !== held_gy ||
                out_eol !== held_eol || out_eof !== held_eof) begin
                n_fail++;
                $display("FAIL stall_hold: got v=%0b gx=%0d gy=%0d eol=%0b eof=%0b, required v=1 gx=%0d gy=%0d eol=%0b eof=%0b",
                         out_valid, out_gx_abs, out_gy_abs, out_eol, out_eof,
                         held_gx, held_gy, held_eol, held_eof);
            end
        end
        held_v   = out_valid && !out_ready;
        held_gx  = out_gx_abs;
        held_gy  = out_gy_abs;
        held_eol = out_eol;
        held_eof = out_eof;
        if (out_valid && out_ready) begin
            out_cnt++;
            eol_cnt += int'(out_eol);
            eof_cnt += int'(out_eof);
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL extra_output: got gx=%0d gy=%0d with no output due", out_gx_abs, out_gy_abs);
            end else begin
                e = exp_q.pop_front();
                if (e.r == probe_r && e.c == probe_c) begin
                    probe_gx = int'(out_gx_abs);
                    probe_gy = int'(out_gy_abs);
                end
                if (int'(out_gx_abs) != e.gx || int'(out_gy_abs) != e.gy ||
                    out_eol !== e.eol || out_eof !== e.eof) begin
                    n_fail++;
                    $display("FAIL out(%0d,%0d): got gx=%0d gy=%0d eol=%0b eof=%0b, required gx=%0d gy=%0d eol=%0b eof=%0b",
                             e.r, e.c, out_gx_abs, out_gy_abs, out_eol, out_eof,
                             e.gx, e.gy, e.eol, e.eof);
                end
            end
        end
        @(posedge clk);
        if (acc) model_accept(pix, sof);
    endtask

    task automatic send_pixels(input int kind, input int val, input int stall, input bit first_sof, input int n);
        bit acc, v, rdy, sof;
        int pix, tries;
        for (int i = 0; i < n && !hung; i++) begin
            pix   = gen(kind, val, i % W);
            sof   = first_sof && (i == 0);
            acc   = 1'b0;
            tries = 0;
            while (!acc && !hung) begin
                v   = (stall == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
                rdy = (stall == 0) ? 1'b1 :
                      (stall == 1) ? (cyc % 3 == 0) : 1'(($urandom_range(0, 1)));
                cycle(v, pix, sof, rdy, acc);
                tries++;
                if (tries > 64) begin
                    hung = 1'b1;
                    check("input_accept_timeout", tries, 0);
                end
            end
        end
    endtask

    task automatic drain();
        bit acc;
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            cycle(1'b0, 0, 1'b0, 1'b1, acc);
            k++;
        end
        repeat (4) cycle(1'b0, 0, 1'b0, 1'b1, acc);
        check("drain_pending", exp_q.size(), 0);
    endtask

    task automatic clear_counts(input int pc);
        out_cnt  = 0;
        eol_cnt  = 0;
        eof_cnt  = 0;
        probe_r  = 10;
        probe_c  = pc;
        probe_gx = -1;
        probe_gy = -1;
    endtask

    case_t cases[7];

    initial begin
        cases[0] = '{kind:0, val:100, stall:0, sof:1'b1, probe_c:10, exp_gx:0,   exp_gy:0};
        cases[1] = '{kind:1, val:0,   stall:0, sof:1'b0, probe_c:10, exp_gx:32,  exp_gy:0};
        cases[2] = '{kind:2, val:0,   stall:0, sof:1'b0, probe_c:31, exp_gx:255, exp_gy:0};
        cases[3] = '{kind:2, val:0,   stall:0, sof:1'b0, probe_c:32, exp_gx:255, exp_gy:0};
        cases[4] = '{kind:2, val:0,   stall:0, sof:1'b0, probe_c:33, exp_gx:0,   exp_gy:0};
        cases[5] = '{kind:1, val:0,   stall:1, sof:1'b0, probe_c:20, exp_gx:32,  exp_gy:0};
        cases[6] = '{kind:3, val:0,   stall:2, sof:1'b1, probe_c:-1, exp_gx:-1,  exp_gy:-1};
        clear_counts(-1);

        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_gx",        int'(out_gx_abs), 0);
        check("reset_gy",        int'(out_gy_abs), 0);
        check("reset_eol",       int'(out_eol), 0);
        check("reset_eof",       int'(out_eof), 0);
        check("reset_in_ready",  int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            clear_counts(cases[i].probe_c);
            send_pixels(cases[i].kind, cases[i].val, cases[i].stall, cases[i].sof, W*H);
            drain();
            check($sformatf("case%0d_count", i), out_cnt, (W-2)*(H-2));
            check($sformatf("case%0d_eol", i), eol_cnt, H-2);
            check($sformatf("case%0d_eof", i), eof_cnt, 1);
            if (cases[i].exp_gx >= 0) begin
                check($sformatf("case%0d_probe_gx", i), probe_gx, cases[i].exp_gx);
                check($sformatf("case%0d_probe_gy", i), probe_gy, cases[i].exp_gy);
            end
        end

        // Abort a ramp frame at (10,5) with a new uniform-50 frame.
        clear_counts(10);
        send_pixels(1, 0, 0, 1'b0, 10*W + 5);
        send_pixels(0, 50, 0, 1'b1, W*H);
        drain();
        check("abort_count", out_cnt, 8*(W-2) + 3 + (W-2)*(H-2));
        check("abort_eol", eol_cnt, 8 + (H-2));
        check("abort_eof", eof_cnt, 1);
        check("abort_probe_gx", probe_gx, 0);

        // Reset pulse at row 20, then a clean frame with no sof.
        clear_counts(-1);
        send_pixels(0, 100, 0, 1'b0, 20*W);
        #2;
        check("pre_reset_out_valid", int'(out_valid), 1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("async_reset_out_valid", int'(out_valid), 0);
        exp_q.delete();
        held_v = 1'b0;
        mr = 0;
        mc = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_counts(10);
        send_pixels(0, 100, 0, 1'b0, W*H);
        drain();
        check("post_reset_count", out_cnt, (W-2)*(H-2));
        check("post_reset_eol", eol_cnt, H-2);
        check("post_reset_eof", eof_cnt, 1);
        check("post_reset_probe_gx", probe_gx, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_grad_stage.md
Name: sobel_grad_stage

Overview:
Streaming Sobel gradient stage that sits directly upstream of the 8-bit approximate multiplier in the edge-detector datapath.
- Accepts one raster-order 8-bit grayscale pixel per cycle.
- Buffers two image lines and forms a 3x3 window.
- Computes Gx and Gy, then emits saturated |Gx| and |Gy| as 8-bit operands; downstream squares and sums them for magnitude.
- Valid/ready handshake on both sides.

Parameters:
IMG_W, 64, pixels per line (>=3)
IMG_H, 64, lines per frame (>=3)
PIX_W, 8, pixel and output operand width

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_pix/in_sof valid
in_ready  output  1  stage accepts pixel this cycle
in_pix  input  PIX_W  grayscale pixel, raster order
in_sof  input  1  marks first pixel of a frame
out_valid  output  1  out_* valid
out_ready  input  1  downstream accepts this cycle
out_gx_abs  output  PIX_W  min(|Gx|,255)
out_gy_abs  output  PIX_W  min(|Gy|,255)
out_eol  output  1  last output of an output line
out_eof  output  1  last output of the frame

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0; out_gx_abs, out_gy_abs, out_eol, out_eof = 0.
  - col/row counters = 0; window registers = 0.
  - Line buffer contents are don't-care; row counter gating guarantees no output uses them.
- Pipeline enable en = out_ready | ~out_valid. in_ready = en.
- A pixel is accepted when in_valid & in_ready.
- Stalled outputs hold stable until accepted.
- Two pipeline stages, latency 2 accepted-enable cycles from pixel accept to out_valid:
  - S1: line-buffer read/write, window shift, counter update, window-valid flag.
  - S2: arithmetic, abs, saturation, output register.
- Window for the accepted pixel at (row r, col c):
  - Rows r-2..r, cols c-2..c, from two line buffers of IMG_W x PIX_W plus the incoming pixel.
  - Line buffer 0 holds row r-1; line buffer 1 holds row r-2.
  - On accept, read index c, write in_pix into buffer 0 and the old buffer 0 value into buffer 1.
- Window is valid iff r>=2 and c>=2. Output corresponds to center (r-1, c-1).
- Border pixels produce no output: exactly (IMG_W-2)*(IMG_H-2) outputs per frame.
- Gx = (w02 + 2*w12 + w22) - (w00 + 2*w10 + w20). Gy = (w20 + 2*w21 + w22) - (w00 + 2*w01 + w02).
- Use 11-bit signed arithmetic (range +/-1020). Take abs, then saturate: any value >255 outputs 255.
- out_eol=1 when c==IMG_W-1. out_eof=1 when c==IMG_W-1 and r==IMG_H-1.
- Counters:
  - col wraps IMG_W-1 -> 0 and increments row.
  - row wraps IMG_H-1 -> 0.
- in_sof on an accepted pixel forces that pixel to (0,0), regardless of the current count.
  - A mid-frame sof aborts the frame; outputs already in the pipeline still drain.
  - A new frame never needs in_sof if the previous frame was complete.
- Accept and output in the same cycle is a normal flow: throughput 1 pixel/cycle when out_ready=1.
- Reset asserted mid-frame: all state cleared immediately, out_valid drops asynchronously, and the next frame starts at (0,0).

Decomposition:
- Shared package sobel_pkg:
  - PIX_W=8, GRAD_W=11, SAT_MAX=8'd255.
  - Signed gradient typedef.
  - Window-position index constants.
- One sub-module: sobel_line_buf. Single-clock line RAM, IMG_W deep, synchronous read, with the shift/write described above.
- Arithmetic stays inline in S2.

Test Plan:
- Uniform frame, all pixels 100, out_ready=1 -> 3844 outputs (62x62), all gx=gy=0; out_eol every 62nd output; one out_eof on the last output.
- Horizontal ramp, pix=4*col -> every output gx_abs=32, gy_abs=0.
- Vertical step, cols<32 = 0, cols>=32 = 200:
  - centers col 31 and 32 -> gx_abs=255 (saturated from 800), gy_abs=0.
  - all other columns -> 0.
- Backpressure: ramp frame with out_ready toggled in a 1-0-0 pattern -> identical output sequence to the no-stall run; no drops or duplicates; out_* stable while out_valid & ~out_ready.
- Mid-frame in_sof at row 10, col 5, then a full uniform-50 frame -> the aborted frame emits no further window outputs after drain; the new frame gives exactly 3844 zero outputs.
- rst_n pulsed low at row 20 -> out_valid=0 immediately; the following full frame matches the uniform-frame golden result exactly.
